// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Purpose:
//   Parametrised N-digit BCD up/down counter. It is the general event or
//   timebase counter for 7-segment display multiplexers and cascaded counter
//   chains.
//
//   Features:
//     - synchronous clear
//     - parallel load with per-digit clamping to 9
//     - wrap or saturate at the ends of the range
//     - terminal count for the current direction
//     - one-cycle carry/borrow pulse
//     - sticky overflow flag
//     - single-digit readout selected by `sel`
//
// Parameters:
//   N    - number of BCD digits (1..8)
//   SELW - width of sel, 2**SELW >= N
//   WRAP - 1: wrap around at the end of the range, 0: saturate
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   clk_en   in   count enable, one step per enabled cycle
//   up       in   direction, 1 = up, 0 = down
//   clr      in   synchronous clear (beats load and count)
//   load     in   synchronous parallel load (beats count)
//   load_val in   load value, digit i at [4i+3:4i]
//   sel      in   digit select for sal_aux
//   sal      out  count value, digit 0 least significant
//   sal_aux  out  digit `sel` of sal, 0 when sel >= N
//   tc       out  terminal count for the current direction
//   carry    out  one-cycle carry/borrow pulse
//   ovf      out  sticky overflow/underflow flag
//   load_err out  one-cycle pulse, a loaded digit was clamped to 9
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
   parameter int N    = 4,
   parameter int SELW = 2,
   parameter bit WRAP = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clk_en,
   input  logic            up,
   input  logic            clr,
   input  logic            load,
   input  logic [N*4-1:0]  load_val,
   input  logic [SELW-1:0] sel,
   output logic [N*4-1:0]  sal,
   output logic [3:0]      sal_aux,
   output logic            tc,
   output logic            carry,
   output logic            ovf,
   output logic            load_err
);

   logic [N-1:0][3:0] digit_q;
   logic [N-1:0][3:0] digit_d;
   logic              carry_q;
   logic              carry_d;
   logic              ovf_q;
   logic              ovf_d;
   logic              load_err_q;
   logic              load_err_d;

   logic              all_nine;
   logic              all_zero;
   logic              end_of_range;
   logic              ripple;
   logic              any_clamped;
   logic [3:0]        load_digit;

   // Whole-count extremes. They drive the terminal count and the
   // end-of-range detection.
   always_comb begin
      all_nine = 1'b1;
      all_zero = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (digit_q[i] != 4'd9) all_nine = 1'b0;
         if (digit_q[i] != 4'd0) all_zero = 1'b0;
      end
   end

   // tc is deliberately not gated by clk_en. This lets a downstream stage
   // cascade with next.clk_en = clk_en & tc.
   assign tc           = up ? all_nine : all_zero;
   assign end_of_range = clk_en & tc;

   // Next state, in priority order: clear, then load, then count.
   //
   // When counting, `ripple` says whether every lower digit is at its
   // rollover value (9 going up, 0 going down). While it holds, the current
   // digit steps.
   //
   // At the end of the range the digit chain would itself produce the
   // wrapped value. It is still written out explicitly, so that the
   // saturating case reads as a plain hold.
   always_comb begin
      digit_d     = digit_q;
      carry_d     = 1'b0;
      ovf_d       = ovf_q;
      load_err_d  = 1'b0;
      ripple      = 1'b1;
      any_clamped = 1'b0;
      load_digit  = 4'd0;

      if (clr) begin
         digit_d = '0;
         ovf_d   = 1'b0;
      end
      else if (load) begin
         for (int i = 0; i < N; i++) begin
            load_digit = load_val[4*i +: 4];
            if (load_digit > 4'd9) begin
               load_digit  = 4'd9;
               any_clamped = 1'b1;
            end
            digit_d[i] = load_digit;
         end
         load_err_d = any_clamped;
         ovf_d      = 1'b0;
      end
      else if (clk_en) begin
         if (end_of_range) begin
            carry_d = 1'b1;
            ovf_d   = 1'b1;
            if (WRAP) begin
               for (int i = 0; i < N; i++) begin
                  digit_d[i] = up ? 4'd0 : 4'd9;
               end
            end
         end
         else begin
            for (int i = 0; i < N; i++) begin
               if (ripple) begin
                  if (up) begin
                     digit_d[i] = (digit_q[i] >= 4'd9) ? 4'd0 : digit_q[i] + 4'd1;
                  end
                  else begin
                     digit_d[i] = (digit_q[i] == 4'd0 || digit_q[i] > 4'd9) ?
                                  4'd9 : digit_q[i] - 4'd1;
                  end
               end
               ripple = ripple & (up ? (digit_q[i] == 4'd9) : (digit_q[i] == 4'd0));
            end
         end
      end
   end

   // State registers, cleared asynchronously while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit_q    <= '0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         load_err_q <= 1'b0;
      end
      else begin
         digit_q    <= digit_d;
         carry_q    <= carry_d;
         ovf_q      <= ovf_d;
         load_err_q <= load_err_d;
      end
   end

   // Unregistered digit readout. A select value past the last digit reads 0.
   always_comb begin
      sal_aux = 4'd0;
      for (int i = 0; i < N; i++) begin
         if (sel == SELW'(i)) sal_aux = digit_q[i];
      end
   end

   assign sal      = digit_q;
   assign carry    = carry_q;
   assign ovf      = ovf_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Three counters share one stimulus stream:
//   dut_wrap - 4 digits, wrapping
//   dut_sat  - 4 digits, saturating
//   dut_n3   - 3 digits, wrapping
//
// A reference model keeps each count as a plain integer and converts it to
// BCD only for comparison.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        up;
   logic        clr;
   logic        load;
   logic [15:0] load_val;
   logic [1:0]  sel;

   logic [15:0] sal_a;
   logic [15:0] sal_b;
   logic [11:0] sal_c;
   logic [3:0]  aux_a;
   logic [3:0]  aux_b;
   logic [3:0]  aux_c;
   logic        tc_a;
   logic        tc_b;
   logic        tc_c;
   logic        carry_a;
   logic        carry_b;
   logic        carry_c;
   logic        ovf_a;
   logic        ovf_b;
   logic        ovf_c;
   logic        lerr_a;
   logic        lerr_b;
   logic        lerr_c;

   int checks = 0;
   int errors = 0;

   // Reference model state, one entry per counter instance.
   int m_val   [3];
   bit m_ovf   [3];
   bit m_carry [3];
   bit m_lerr  [3];
   int n_dig   [3] = '{4, 4, 3};
   bit m_wrap  [3] = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   bcd_updown_counter #(.N(4), .SELW(2), .WRAP(1'b1)) dut_wrap (
      .clk(clk), .rst(rst), .clk_en(clk_en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .sel(sel), .sal(sal_a), .sal_aux(aux_a), .tc(tc_a),
      .carry(carry_a), .ovf(ovf_a), .load_err(lerr_a)
   );

   bcd_updown_counter #(.N(4), .SELW(2), .WRAP(1'b0)) dut_sat (
      .clk(clk), .rst(rst), .clk_en(clk_en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .sel(sel), .sal(sal_b), .sal_aux(aux_b), .tc(tc_b),
      .carry(carry_b), .ovf(ovf_b), .load_err(lerr_b)
   );

   bcd_updown_counter #(.N(3), .SELW(2), .WRAP(1'b1)) dut_n3 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .up(up), .clr(clr), .load(load),
      .load_val(load_val[11:0]), .sel(sel), .sal(sal_c), .sal_aux(aux_c), .tc(tc_c),
      .carry(carry_c), .ovf(ovf_c), .load_err(lerr_c)
   );

   function automatic int pow10(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [31:0] to_bcd(input int v, input int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   // Reset clears every modelled value and flag.
   task automatic modelReset();
      for (int k = 0; k < 3; k++) begin
         m_val[k]   = 0;
         m_ovf[k]   = 1'b0;
         m_carry[k] = 1'b0;
         m_lerr[k]  = 1'b0;
      end
   endtask

   // One rising edge of the model, using the inputs currently applied.
   task automatic modelEdge();
      int v;
      int d;
      int maxv;
      for (int k = 0; k < 3; k++) begin
         maxv       = pow10(n_dig[k]) - 1;
         m_carry[k] = 1'b0;
         m_lerr[k]  = 1'b0;
         if (clr) begin
            m_val[k] = 0;
            m_ovf[k] = 1'b0;
         end
         else if (load) begin
            v = 0;
            for (int i = 0; i < n_dig[k]; i++) begin
               d = int'(load_val[4*i +: 4]);
               if (d > 9) begin
                  d = 9;
                  m_lerr[k] = 1'b1;
               end
               v = v + d * pow10(i);
            end
            m_val[k] = v;
            m_ovf[k] = 1'b0;
         end
         else if (clk_en) begin
            if (up) begin
               if (m_val[k] == maxv) begin
                  m_carry[k] = 1'b1;
                  m_ovf[k]   = 1'b1;
                  if (m_wrap[k]) m_val[k] = 0;
               end
               else m_val[k] = m_val[k] + 1;
            end
            else begin
               if (m_val[k] == 0) begin
                  m_carry[k] = 1'b1;
                  m_ovf[k]   = 1'b1;
                  if (m_wrap[k]) m_val[k] = maxv;
               end
               else m_val[k] = m_val[k] - 1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string step);
      logic [31:0] o_sal;
      logic [31:0] o_aux;
      logic        o_tc;
      logic        o_carry;
      logic        o_ovf;
      logic        o_lerr;
      logic [31:0] e_sal;
      logic [31:0] e_aux;
      logic        e_tc;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: begin
               o_sal = 32'(sal_a); o_aux = 32'(aux_a); o_tc = tc_a;
               o_carry = carry_a; o_ovf = ovf_a; o_lerr = lerr_a;
            end
            1: begin
               o_sal = 32'(sal_b); o_aux = 32'(aux_b); o_tc = tc_b;
               o_carry = carry_b; o_ovf = ovf_b; o_lerr = lerr_b;
            end
            default: begin
               o_sal = 32'(sal_c); o_aux = 32'(aux_c); o_tc = tc_c;
               o_carry = carry_c; o_ovf = ovf_c; o_lerr = lerr_c;
            end
         endcase
         e_sal = to_bcd(m_val[k], n_dig[k]);
         e_tc  = up ? (m_val[k] == pow10(n_dig[k]) - 1) : (m_val[k] == 0);
         e_aux = (int'(sel) < n_dig[k]) ? ((e_sal >> (4 * int'(sel))) & 32'hf) : 32'h0;
         chk($sformatf("%s/u%0d/sal", step, k),      o_sal,          e_sal);
         chk($sformatf("%s/u%0d/sal_aux", step, k),  o_aux,          e_aux);
         chk($sformatf("%s/u%0d/tc", step, k),       32'(o_tc),      32'(e_tc));
         chk($sformatf("%s/u%0d/carry", step, k),    32'(o_carry),   32'(m_carry[k]));
         chk($sformatf("%s/u%0d/ovf", step, k),      32'(o_ovf),     32'(m_ovf[k]));
         chk($sformatf("%s/u%0d/load_err", step, k), 32'(o_lerr),    32'(m_lerr[k]));
      end
   endtask

   // Apply inputs away from the edge, clock once, then check.
   task automatic applyStimulus(input string step, input logic c, input logic l,
                                input logic e, input logic u, input logic [15:0] lv,
                                input logic [1:0] s);
      clr      = c;
      load     = l;
      clk_en   = e;
      up       = u;
      load_val = lv;
      sel      = s;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(step);
   endtask

   // Pull rst low between edges, check the immediate clear, then release.
   task automatic midCycleReset(input string step);
      #2;
      rst = 1'b0;
      modelReset();
      #1;
      checkOutput(step);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      logic [15:0] lv;
      logic        c;
      logic        l;
      int          r;

      rst      = 1'b0;
      clr      = 1'b0;
      load     = 1'b0;
      clk_en   = 1'b0;
      up       = 1'b1;
      load_val = '0;
      sel      = '0;

      // Reset state, with tc checked in both directions.
      #2;
      modelReset();
      checkOutput("reset_up");
      up = 1'b0;
      #1;
      checkOutput("reset_down");

      // Release rst mid-cycle.
      #9;
      rst = 1'b1;

      // Async reset while counting.
      applyStimulus("t1_load", 0, 1, 0, 1, 16'h0120, 2'd0);
      for (int i = 0; i < 3; i++) applyStimulus("t1_count", 0, 0, 1, 1, 16'h0, 2'd1);
      midCycleReset("t1_async_rst");
      applyStimulus("t1_after_rst", 0, 0, 1, 1, 16'h0, 2'd0);

      // Up wrap, then ovf stays set through further counts.
      applyStimulus("t2_load", 0, 1, 0, 1, 16'h9998, 2'd0);
      applyStimulus("t2_to_9999", 0, 0, 1, 1, 16'h0, 2'd3);
      applyStimulus("t2_wrap", 0, 0, 1, 1, 16'h0, 2'd3);
      for (int i = 0; i < 5; i++) applyStimulus("t2_sticky", 0, 0, 1, 1, 16'h0, 2'd0);

      // Down borrow chain, then underflow from 0000.
      applyStimulus("t3_load", 0, 1, 0, 0, 16'h1000, 2'd3);
      applyStimulus("t3_borrow", 0, 0, 1, 0, 16'h0, 2'd3);
      applyStimulus("t3_load0", 0, 1, 0, 0, 16'h0000, 2'd0);
      applyStimulus("t3_under", 0, 0, 1, 0, 16'h0, 2'd0);

      // End-of-range steps hold on the saturating instance.
      applyStimulus("t4_load", 0, 1, 0, 1, 16'h9999, 2'd2);
      for (int i = 0; i < 3; i++) applyStimulus("t4_sat_up", 0, 0, 1, 1, 16'h0, 2'd2);
      applyStimulus("t4_load0", 0, 1, 0, 0, 16'h0000, 2'd0);
      applyStimulus("t4_sat_down", 0, 0, 1, 0, 16'h0, 2'd0);

      // Load clamping, and clr beating load.
      applyStimulus("t5_clamp", 0, 1, 1, 1, 16'h1A3F, 2'd2);
      applyStimulus("t5_after", 0, 0, 0, 1, 16'h0, 2'd0);
      applyStimulus("t5_clr_load", 1, 1, 1, 1, 16'hFFFF, 2'd0);

      // Combinational readout sweep.
      applyStimulus("t6_load", 0, 1, 0, 1, 16'h4321, 2'd0);
      clk_en = 1'b0;
      load   = 1'b0;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         checkOutput($sformatf("t6_sel%0d", s));
      end

      // Randomised traffic, biased towards the ends of the range.
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 99));
         c = (r < 4);
         l = (r >= 3 && r < 14);
         case ($urandom_range(0, 3))
            0:       lv = 16'($urandom);
            1:       lv = 16'h9990 | 16'($urandom_range(0, 9));
            2:       lv = 16'($urandom_range(0, 9));
            default: lv = 16'h9999;
         endcase
         applyStimulus("rand", c, l, ($urandom_range(0, 3) != 0), 1'($urandom),
                       lv, 2'($urandom));
         if ($urandom_range(0, 49) == 0) midCycleReset("rand_rst");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised N-digit BCD up/down counter with synchronous clear, parallel load with per-digit BCD validation, wrap or saturate end-of-range behaviour, terminal-count and carry/borrow outputs, a sticky overflow flag, and single-digit readout by select. It is the successor to the team's fixed-direction BCD digit-chain counter. It serves as the general event or timebase counter feeding 7-segment display multiplexers and cascaded counter chains.

## Interface
- N, 4: number of BCD digits; legal range 1..8.
- SELW, 2: width of `sel`; must satisfy 2^SELW >= N.
- WRAP, 1: end-of-range behaviour. 1 wraps around; 0 saturates.

- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- clk_en  in  1  count enable, qualifying one count step per cycle.
- up  in  1  direction. 1 counts up; 0 counts down.
- clr  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- load_val  in  N*4  load value; digit i is `load_val[4i+3:4i]`.
- sel  in  SELW  digit select for `sal_aux`.
- sal  out  N*4  count value; digit i is `sal[4i+3:4i]`, with digit 0 the least significant.
- sal_aux  out  4  digit `sel` of `sal`; reads 0 when sel >= N.
- tc  out  1  terminal count for the current direction.
- carry  out  1  one-cycle carry/borrow-out pulse.
- ovf  out  1  sticky overflow/underflow flag.
- load_err  out  1  one-cycle pulse indicating an invalid BCD digit in `load_val`.

## Operation
- Per-edge priority, highest first:
  - rst (asynchronous)
  - clr
  - load
  - clk_en count
- `clr` and `load` act regardless of `clk_en`.
- rst low: all digits, carry, ovf and load_err go to 0 immediately, without waiting for a clock edge. They stay 0 while rst is low.
- clr: all digits go to 0; ovf, carry and load_err go to 0. clr takes precedence over a simultaneous load.
- load:
  - Each digit is taken from `load_val`.
  - Any digit > 9 is clamped to 9, and load_err pulses if at least one digit was clamped.
  - ovf and carry are cleared.
- Count up with clk_en=1, up=1:
  - Digit i increments when all lower digits are 9; digit 0 always steps.
  - A digit at 9 that steps goes to 0.
- Count down with clk_en=1, up=0:
  - Digit i decrements when all lower digits are 0; digit 0 always steps.
  - A digit at 0 that steps goes to 9.
- End of range: an enabled step up from all-9s, or an enabled step down from all-0s.
  - WRAP=1: count wraps to all-0s (up) or all-9s (down).
  - WRAP=0: count holds at its current value.
  - In both modes, carry pulses and ovf sets.
- tc = 1 when up=1 and count is all-9s, or when up=0 and count is all-0s. tc is not gated by clk_en, so it can be used for cascading as `next.clk_en = clk_en & tc`.
- `sal_aux` is a pure mux of `sal`. It is not registered.
- Digits never hold a value > 9 under any input sequence.

## Timing
- Count, clear and load results appear on `sal` in the cycle after the rising edge that samples them; latency is 1 cycle.
- carry and load_err are registered: each is high for exactly the one cycle following the causing edge.
- ovf sets on the same edge as the end-of-range step. It stays set until clr, load or rst.
- tc and sal_aux are combinational from registered state and the current `up`/`sel`. They follow a change of `up` or `sel` within the same cycle.
- A direction change takes effect on the next enabled edge. There is no dead cycle.
- Reset values (rst low):
  - sal = 0; sal_aux = 0; carry = 0; ovf = 0; load_err = 0.
  - tc = 1 if up=0, otherwise 0.
- Reset deassertion mid-cycle: the first count is sampled on the first rising edge with rst high.
- An rst assertion between edges during counting clears outputs immediately. No partial step is committed.

## Test plan
All scenarios use N=4.
1. Async reset: count to 0123, drive rst low midway between edges -> sal=0000 before the next edge, ovf=0. Release rst, apply 1 enabled edge -> sal=0001.
2. Up wrap (WRAP=1): load 9998, up=1, clk_en for 2 edges -> 9999 with tc=1, then 0000. carry is high for exactly 1 cycle, ovf=1 and stays set through 5 further counts.
3. Down borrow chain: load 1000, up=0, 1 enabled edge -> 0999. Load 0000 with tc=1, 1 enabled edge -> 9999, carry pulse, ovf=1.
4. Saturate (WRAP=0): load 9999, up=1, 3 enabled edges -> sal stays 9999, carry pulses each cycle, ovf=1. Then up=0 from load 0000, 1 edge -> stays 0000.
5. Load validation and priority:
   - load_val=0x1A3F with clk_en=1 -> sal=1939, load_err high for 1 cycle, ovf cleared, no count applied.
   - clr and load together -> sal=0000, load_err=0.
6. Readout: load 4321, sweep sel=0..3 -> sal_aux = 1, 2, 3, 4 combinationally. With N=3 and SELW=2, sel=3 -> sal_aux=0.
